// File: rtl/tx_ctrl_enc_if.sv
// Command-side and byte-transmitter-side signals of the tx_ctrl command encoder.
// master = encoder, slave = command source plus byte transmitter.
interface tx_ctrl_enc_if;
    logic [7:0] cmdt_dev;
    logic [7:0] cmdt_mod;
    logic [7:0] cmdt_addr;
    logic [7:0] cmdt_data;
    logic       cmdt_vld;
    logic       cmdt_rdy;
    logic       cmdt_done;
    logic       cmdt_err;
    logic       tx_vld;
    logic [7:0] tx_data;
    logic       tx_done;

    modport master (
        input  cmdt_dev, cmdt_mod, cmdt_addr, cmdt_data, cmdt_vld, tx_done,
        output cmdt_rdy, cmdt_done, cmdt_err, tx_vld, tx_data
    );

    modport slave (
        output cmdt_dev, cmdt_mod, cmdt_addr, cmdt_data, cmdt_vld, tx_done,
        input  cmdt_rdy, cmdt_done, cmdt_err, tx_vld, tx_data
    );
endinterface

// File: rtl/tx_ctrl_enc.sv
// Serialises one dev/mod/addr/data command into bytes for the UART transmitter.
// Define TX_CTRL_CHKSUM_EN to append an 8-bit wrap-around checksum byte.
module tx_ctrl_enc #(
    parameter logic [15:0] GAP_CYC     = 16'd16,
    parameter logic [19:0] TIMEOUT_CYC = 20'd100000
) (
    input  logic          clk_sys,
    input  logic          rst_n,
    tx_ctrl_enc_if.master bus
);
    // state  | meaning
    // S_IDLE | ready for a command
    // S_SEND | tx_vld high for the current byte
    // S_WAIT | waiting for tx_done, timeout armed
    // S_GAP  | inter-byte idle gap
    // S_DONE | cmdt_done pulse
    // S_FAIL | cmdt_err pulse, remaining bytes dropped
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEND = 3'd1,
        S_WAIT = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4,
        S_FAIL = 3'd5
    } state_t;

`ifdef TX_CTRL_CHKSUM_EN
    localparam logic [2:0] LAST_IDX = 3'd4;
`else
    localparam logic [2:0] LAST_IDX = 3'd3;
`endif

    state_t      state, nxt;
    logic [7:0]  dev_q, mod_q, addr_q, data_q;
    logic [2:0]  idx, idx_nxt;
    logic [19:0] cnt_wait;
    logic [15:0] cnt_gap;
    logic [7:0]  tx_data_q;
    logic [7:0]  byte_sel;
    logic        latch;

`ifdef TX_CTRL_CHKSUM_EN
    logic [7:0] chksum;
    assign chksum = dev_q + mod_q + addr_q + data_q;
`endif

    always_comb begin
        nxt     = state;
        idx_nxt = idx;
        latch   = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.cmdt_vld) begin
                    latch   = 1'b1;
                    idx_nxt = 3'd0;
                    nxt     = S_SEND;
                end
            end
            S_SEND: nxt = S_WAIT;
            S_WAIT: begin
                // tx_done takes priority over a coincident timeout
                if (bus.tx_done) begin
                    if (idx == LAST_IDX) begin
                        nxt = S_DONE;
                    end else begin
                        idx_nxt = idx + 3'd1;
                        nxt     = (GAP_CYC == 16'd0) ? S_SEND : S_GAP;
                    end
                end else if (cnt_wait == TIMEOUT_CYC) begin
                    nxt = S_FAIL;
                end
            end
            S_GAP: begin
                if (cnt_gap == GAP_CYC - 16'd1) nxt = S_SEND;
            end
            S_DONE:  nxt = S_IDLE;
            S_FAIL:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // On acceptance the byte registers are not loaded yet, so dev comes straight from the port.
    always_comb begin
        byte_sel = 8'h00;
        if (latch) begin
            byte_sel = bus.cmdt_dev;
        end else begin
            case (idx_nxt)
                3'd0: byte_sel = dev_q;
                3'd1: byte_sel = mod_q;
                3'd2: byte_sel = addr_q;
                3'd3: byte_sel = data_q;
`ifdef TX_CTRL_CHKSUM_EN
                3'd4: byte_sel = chksum;
`endif
                default: byte_sel = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= 3'd0;
            cnt_wait  <= 20'd0;
            cnt_gap   <= 16'd0;
            dev_q     <= 8'h00;
            mod_q     <= 8'h00;
            addr_q    <= 8'h00;
            data_q    <= 8'h00;
            tx_data_q <= 8'h00;
        end else begin
            state    <= nxt;
            idx      <= idx_nxt;
            cnt_wait <= (state == S_WAIT) ? cnt_wait + 20'd1 : 20'd0;
            cnt_gap  <= (state == S_GAP)  ? cnt_gap + 16'd1  : 16'd0;
            if (latch) begin
                dev_q  <= bus.cmdt_dev;
                mod_q  <= bus.cmdt_mod;
                addr_q <= bus.cmdt_addr;
                data_q <= bus.cmdt_data;
            end
            if (nxt == S_SEND) tx_data_q <= byte_sel;
        end
    end

    assign bus.cmdt_rdy  = (state == S_IDLE);
    assign bus.tx_vld    = (state == S_SEND);
    assign bus.cmdt_done = (state == S_DONE);
    assign bus.cmdt_err  = (state == S_FAIL);
    assign bus.tx_data   = tx_data_q;
endmodule

// File: tb/tb_tx_ctrl_enc.sv
// Randomised cycle-accurate bench for tx_ctrl_enc with a frame-level reference model.
// Honours TX_CTRL_CHKSUM_EN for the expected frame length.
module tb_tx_ctrl_enc;
    localparam int GAP = 2;
    localparam int TMO = 20;
`ifdef TX_CTRL_CHKSUM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic clk_sys = 1'b0;
    logic rst_n   = 1'b0;
    always #5 clk_sys = ~clk_sys;

    tx_ctrl_enc_if bus ();

    tx_ctrl_enc #(
        .GAP_CYC     (16'(GAP)),
        .TIMEOUT_CYC (20'(TMO))
    ) dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .bus     (bus.master)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(negedge clk_sys);
    endtask

    // Busy-time command attempts that must be ignored.
    task automatic noise();
        bus.cmdt_vld  = ($urandom_range(0, 3) == 0);
        bus.cmdt_dev  = 8'h33;
        bus.cmdt_mod  = 8'($urandom);
        bus.cmdt_addr = 8'($urandom);
        bus.cmdt_data = 8'($urandom);
    endtask

    task automatic quiet(input string tag);
        check({tag, "_vld"},  bus.tx_vld,    0);
        check({tag, "_done"}, bus.cmdt_done, 0);
        check({tag, "_err"},  bus.cmdt_err,  0);
        check({tag, "_rdy"},  bus.cmdt_rdy,  0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_vld"},  bus.tx_vld,    0);
        check({tag, "_data"}, bus.tx_data,   0);
        check({tag, "_done"}, bus.cmdt_done, 0);
        check({tag, "_err"},  bus.cmdt_err,  0);
        check({tag, "_rdy"},  bus.cmdt_rdy,  1);
    endtask

    // Model: bytes go out in order dev,mod,addr,data[,sum]; first tx_vld one cycle after
    // acceptance; a byte is acknowledged if tx_done comes 1..TMO+1 cycles after its tx_vld,
    // otherwise cmdt_err fires TMO+2 cycles after tx_vld; next tx_vld GAP+1 cycles after tx_done.
    task automatic run_cmd(input logic [7:0] d, input logic [7:0] m, input logic [7:0] a,
                           input logic [7:0] x, input int to_idx, input int rst_idx, input int fix_dly);
        logic [7:0] eb [5];
        int k;
        eb[0] = d; eb[1] = m; eb[2] = a; eb[3] = x;
        eb[4] = 8'((int'(d) + int'(m) + int'(a) + int'(x)) % 256);

        check("accept_rdy", bus.cmdt_rdy, 1);
        bus.cmdt_vld  = 1'b1;
        bus.cmdt_dev  = d;
        bus.cmdt_mod  = m;
        bus.cmdt_addr = a;
        bus.cmdt_data = x;
        bus.tx_done   = 1'b0;
        tick();
        for (int i = 0; i < NB; i++) begin
            check("send_vld",  bus.tx_vld, 1);
            check("send_data", bus.tx_data, eb[i]);
            check("send_rdy",  bus.cmdt_rdy, 0);
            check("send_done", bus.cmdt_done, 0);
            if (i == rst_idx) begin
                rst_n = 1'b0;
                bus.cmdt_vld = 1'b0;
                bus.tx_done  = 1'b0;
                #1;
                check_reset_vals("rst_async");
                tick();
                tick();
                rst_n = 1'b1;
                for (int j = 0; j < 6; j++) begin
                    tick();
                    check_reset_vals("rst_after");
                end
                return;
            end
            noise();
            if (i == to_idx) begin
                for (int j = 1; j <= TMO + 1; j++) begin
                    tick();
                    quiet("to_wait");
                    noise();
                end
                bus.cmdt_vld = 1'b0;
                tick();
                check("to_err",  bus.cmdt_err, 1);
                check("to_done", bus.cmdt_done, 0);
                check("to_vld",  bus.tx_vld, 0);
                tick();
                check("to_rdy",  bus.cmdt_rdy, 1);
                check("to_err2", bus.cmdt_err, 0);
                return;
            end
            if (fix_dly > 0) k = fix_dly;
            else case ($urandom_range(0, 3))
                0:       k = 1;
                1:       k = TMO + 1;
                default: k = $urandom_range(1, TMO + 1);
            endcase
            for (int j = 1; j <= k; j++) begin
                tick();
                quiet("wait");
                noise();
                if (j == k) bus.tx_done = 1'b1;
            end
            tick();
            bus.tx_done = 1'b0;
            if (i == NB - 1) begin
                bus.cmdt_vld = 1'b0;
                check("done_pulse", bus.cmdt_done, 1);
                check("done_err",   bus.cmdt_err, 0);
                check("done_vld",   bus.tx_vld, 0);
                check("done_rdy",   bus.cmdt_rdy, 0);
                tick();
                check("post_rdy",   bus.cmdt_rdy, 1);
                check("post_done",  bus.cmdt_done, 0);
                check("post_vld",   bus.tx_vld, 0);
                return;
            end
            for (int g = 0; g < GAP; g++) begin
                quiet("gap");
                noise();
                bus.tx_done = 1'($urandom_range(0, 1));
                tick();
            end
            bus.tx_done = 1'b0;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int j = 0; j < n; j++) begin
            bus.cmdt_vld = 1'b0;
            bus.tx_done  = 1'($urandom_range(0, 1));
            tick();
            check("idle_vld", bus.tx_vld, 0);
            check("idle_rdy", bus.cmdt_rdy, 1);
        end
        bus.tx_done = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int to_idx;
        bus.cmdt_vld  = 1'b0;
        bus.cmdt_dev  = 8'h00;
        bus.cmdt_mod  = 8'h00;
        bus.cmdt_addr = 8'h00;
        bus.cmdt_data = 8'h00;
        bus.tx_done   = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        check_reset_vals("reset");
        rst_n = 1'b1;
        tick();
        idle_cycles(4);

        run_cmd(8'h01, 8'h02, 8'h10, 8'hA5, -1, -1, 5);
        idle_cycles(1);
        run_cmd(8'hFF, 8'hFF, 8'hFF, 8'hFF, -1, -1, 0);
        run_cmd(8'h5A, 8'h6B, 8'h7C, 8'h8D, 0, -1, 0);
        run_cmd(8'h01, 8'h02, 8'h10, 8'hA5, -1, -1, 3);
        run_cmd(8'h11, 8'h22, 8'h44, 8'h88, -1, -1, TMO + 1);
        run_cmd(8'hC3, 8'h3C, 8'h99, 8'h66, 2, -1, 0);
        idle_cycles(2);
        run_cmd(8'h01, 8'h02, 8'h10, 8'hA5, -1, 1, 5);
        run_cmd(8'h0F, 8'hF0, 8'h55, 8'hAA, -1, -1, 1);

        for (int n = 0; n < 40; n++) begin
            to_idx = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, NB - 1)) : -1;
            run_cmd(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), to_idx, -1, 0);
            idle_cycles($urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/tx_ctrl_enc.md
Name: tx_ctrl_enc

Overview:
Command encoder for the control link's transmit direction. Accepts one 4-field command (dev, mod, addr, data) and serialises it as consecutive bytes dev, mod, addr, data to the byte-level transmitter. Uses the same byte order and per-command framing that the rx_ctrl command decoder expects. Sits in control_top/tx_ctrl between the register/command logic and the UART byte transmitter.

Parameters:
GAP_CYC, 16'd16, idle clk_sys cycles inserted after each byte's tx_done before the next byte is issued; 0 means no gap
TIMEOUT_CYC, 20'd100000, maximum clk_sys cycles spent waiting for tx_done on one byte before the command is aborted

Ports:
clk_sys  input  1  system clock; all logic is on the rising edge
rst_n  input  1  asynchronous active-low reset
cmdt_dev  input  8  device byte, sampled when cmdt_vld && cmdt_rdy
cmdt_mod  input  8  module byte, sampled with cmdt_dev
cmdt_addr  input  8  address byte, sampled with cmdt_dev
cmdt_data  input  8  data byte, sampled with cmdt_dev
cmdt_vld  input  1  command request, single-cycle pulse or level
cmdt_rdy  output  1  high only in S_IDLE; the encoder accepts a command this cycle
cmdt_done  output  1  one-cycle pulse: all bytes of the command were acknowledged
cmdt_err  output  1  one-cycle pulse: the command was aborted on timeout
tx_vld  output  1  one-cycle request to the byte transmitter
tx_data  output  8  byte to send; valid when tx_vld=1 and held until the next load
tx_done  input  1  one-cycle pulse from the byte transmitter: the current byte has finished

Behaviour:
- Reset values: tx_vld=0, tx_data=8'h0, cmdt_done=0, cmdt_err=0, byte index=0, counters=0, state=S_IDLE. cmdt_rdy=1 because it decodes S_IDLE.
- The following states are all registered. The state encoding is 3 bits.
- S_IDLE:
  - If cmdt_vld=1, latch all 4 cmdt_* bytes into internal registers, clear the byte index, and go to S_SEND.
  - Otherwise stay in S_IDLE.
- S_SEND:
  - For one cycle, drive tx_vld=1 and tx_data=byte[idx].
  - Order: idx0=dev, idx1=mod, idx2=addr, idx3=data.
  - Next state is S_WAIT.
- S_WAIT:
  - cnt_wait increments each cycle and is cleared on entry.
  - On tx_done: if idx is the last index, go to S_DONE.
  - Otherwise, increment idx and go to S_GAP. If GAP_CYC=0, go directly to S_SEND instead.
  - If cnt_wait==TIMEOUT_CYC and tx_done=0, go to S_FAIL.
  - If tx_done and the timeout hit in the same cycle, tx_done wins.
- S_GAP:
  - cnt_gap counts from 0.
  - When cnt_gap==GAP_CYC-1, go to S_SEND.
- S_DONE: cmdt_done=1 for one cycle, then go to S_IDLE.
- S_FAIL: cmdt_err=1 for one cycle, then go to S_IDLE. Remaining bytes are discarded.
- Latency: the first tx_vld is asserted 1 cycle after the accepting cmdt_vld edge. tx_vld for byte n+1 is asserted GAP_CYC+1 cycles after tx_done of byte n.
- cmdt_vld while cmdt_rdy=0 is ignored and not queued. Latched bytes are unaffected by input changes after acceptance.
- tx_done outside S_WAIT is ignored.
- Counter widths: cnt_wait is 20 bits and cnt_gap is 16 bits. Neither wraps, because exit happens at terminal count.
- Asynchronous reset mid-command aborts immediately to reset values. No partial byte is re-sent.
- cmdt_done and cmdt_err are mutually exclusive and never assert in the same cycle as tx_vld.

Optional Feature:
Macro TX_CTRL_CHKSUM_EN.
- Defined:
  - A fifth byte is sent after the data byte: chksum = (dev+mod+addr+data) mod 256, 8-bit wrap-around sum.
  - The last index becomes 4, and cmdt_done fires after the fifth tx_done.
- Undefined:
  - Exactly 4 bytes are sent, and the last index is 3.
  - No checksum logic is synthesised.
- The far-end decoder must be built with a matching frame length.

Test Plan:
- Basic frame: GAP_CYC=2, dev=01, mod=02, addr=10, data=A5, cmdt_vld pulse, tx_done returned 5 cycles after each tx_vld.
  - tx_data sequence 01,02,10,A5.
  - Each tx_vld lasts 1 cycle.
  - Next tx_vld arrives 3 cycles after each tx_done.
  - cmdt_done pulses once. cmdt_rdy returns high the cycle after.
- Checksum (TX_CTRL_CHKSUM_EN defined), same command: 5 bytes 01,02,10,A5,B8. Operands FF,FF,FF,FF: chksum=FC.
- Timeout: TIMEOUT_CYC=20, never return tx_done.
  - Exactly one tx_vld is issued.
  - cmdt_err pulses; cmdt_done stays 0.
  - Back in S_IDLE; the next command starts from dev.
- Busy rejection: second cmdt_vld (dev=33) asserted during byte 2 → ignored. Frame completes with the original bytes, and only 4 tx_vld occur.
- Race and stray inputs:
  - tx_done in the same cycle as the timeout terminal count → byte accepted, no cmdt_err.
  - Stray tx_done in S_IDLE → no effect.
- Reset mid-frame: assert rst_n=0 after byte 1.
  - All outputs go to reset values asynchronously.
  - After release, cmdt_rdy=1 and no tx_vld occurs without a new cmdt_vld.
